time_preset_ctrl: RTL and testbench
===================================

TIME_PRESET_CTRL -- requirements
Module: time_preset_ctrl

Interface
REQ-001 SHALL have parameter MIN_LIMIT, default 99: highest minute value; legal range 9..99.
REQ-002 SHALL have parameter HOLD_FAST_CNT, default 4: number of slow repeat steps before fast repeat starts; legal range 1..15.
REQ-003 SHALL have parameter CARRY_EN, default 1: 1 = seconds wrap carries or borrows into minutes; 0 = seconds wrap alone.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  clock; all state updates on its rising edge.
REQ-006 RES  in  1  synchronous active-high reset.
REQ-007 SEC_PUSH / MIN_PUSH  in  1 each  debounced one-cycle button pulses.
REQ-008 SEC_HOLD / MIN_HOLD  in  1 each  level, high while the button stays pressed.
REQ-009 HALF_SEC_PULSE / TENTH_SEC_PULSE  in  1 each  one-cycle timebase strobes.
REQ-010 UP_DOWN_TOGGLE  in  1  one-cycle pulse that inverts the count direction.
REQ-011 CLEAR  in  1  one-cycle pulse that zeroes the preset.
REQ-012 M_HI / M_LO  out  4 / 4  minute tens / units, BCD.
REQ-013 S_HI / S_LO  out  3 / 4  second tens (0..5) / units (0..9), BCD.
REQ-014 DOWN_MODE  out  1  1 = stepping decrements.
REQ-015 COUNT_UP_SEC_PULSE / COUNT_UP_MIN_PULSE  out  1 each  registered step strobes.
REQ-016 ZERO  out  1  high while the preset reads 00:00.

Function
REQ-017 A seconds step event SHALL occur in cycle N if SEC_PUSH=1, or if the seconds hold FSM issues a repeat; the minutes step event is defined the same way with MIN_PUSH.
REQ-018 Digits SHALL show the result of a cycle-N step from cycle N+1 onward; COUNT_UP_*_PULSE SHALL be high for exactly cycle N+1.
REQ-019 Seconds up-step: units 9->0 increments tens; 59->00; with CARRY_EN=1, 59->00 also increments minutes.
REQ-020 Seconds down-step: units 0->9 decrements tens; 00->59; with CARRY_EN=1, 00->59 also decrements minutes.
REQ-021 Minutes up-step SHALL go MIN_LIMIT->00; minutes down-step SHALL go 00->MIN_LIMIT; all other steps are +/-1 in BCD.
REQ-022 Hold FSM per button has states IDLE, SLOW and FAST:
  - IDLE->SLOW when HOLD=1 and the repeat count clears to 0.
  - SLOW: HALF_SEC_PULSE with HOLD=1 issues a repeat and increments the count.
  - SLOW->FAST on the HOLD_FAST_CNT-th slow repeat.
  - FAST: TENTH_SEC_PULSE with HOLD=1 issues a repeat.
  - Any state->IDLE when HOLD=0.
REQ-023 A PUSH pulse and an FSM repeat in the same cycle SHALL yield a single step.
REQ-024 If seconds and minutes step events coincide, the minutes step SHALL apply, the seconds step SHALL be discarded, and only COUNT_UP_MIN_PULSE SHALL fire.
REQ-025 UP_DOWN_TOGGLE coinciding with a step: the step SHALL use the pre-toggle direction; the new direction applies from N+1.
REQ-026 CLEAR (priority over steps) SHALL set all digits to 0, force both FSMs to IDLE and suppress strobes in N+1; DOWN_MODE is unchanged.
REQ-027 ZERO SHALL be combinational from the digit registers.
REQ-028 Minute tens SHALL never exceed MIN_LIMIT/10, and units SHALL not exceed MIN_LIMIT%10 when tens equal MIN_LIMIT/10.

Reset
REQ-029 RES=1 at a clock edge SHALL set all digits to 0, DOWN_MODE=0, both FSMs to IDLE, repeat counts to 0 and strobes to 0, with ZERO=1 from the next cycle.
REQ-030 RES SHALL override CLEAR, steps and toggles, including mid-hold; no strobe follows reset.

Verification
REQ-031 Reset, then 12 SEC_PUSH -> 00:12, ZERO=0, twelve COUNT_UP_SEC_PULSE strobes each one cycle after its push.
REQ-032 Preset 00:59, SEC_PUSH with CARRY_EN=1 -> 01:00; with CARRY_EN=0 -> 00:00.
REQ-033 From 00:00, UP_DOWN_TOGGLE then SEC_PUSH -> 99:59 (MIN_LIMIT=99); with MIN_LIMIT=59 -> 59:59.
REQ-034 SEC_HOLD held with HOLD_FAST_CNT=4 -> one step per HALF_SEC_PULSE for 4 pulses, then one per TENTH_SEC_PULSE; release -> IDLE and no further steps.
REQ-035 SEC_PUSH and MIN_PUSH in the same cycle at 05:30 -> 06:30 with only COUNT_UP_MIN_PULSE set.
REQ-036 CLEAR during FAST hold at 12:34 -> 00:00, FSM IDLE, DOWN_MODE kept; RES mid-hold -> 00:00 and DOWN_MODE=0.

Source files
------------

// File: rtl/time_preset_ctrl_if.sv
// Button, timebase and display bundle for the time preset controller.
// HOLD_STATE outputs expose each hold FSM (0 idle, 1 slow, 2 fast) for checkers.
interface time_preset_ctrl_if;
  logic       SEC_PUSH;
  logic       MIN_PUSH;
  logic       SEC_HOLD;
  logic       MIN_HOLD;
  logic       HALF_SEC_PULSE;
  logic       TENTH_SEC_PULSE;
  logic       UP_DOWN_TOGGLE;
  logic       CLEAR;
  logic [3:0] M_HI;
  logic [3:0] M_LO;
  logic [2:0] S_HI;
  logic [3:0] S_LO;
  logic       DOWN_MODE;
  logic       COUNT_UP_SEC_PULSE;
  logic       COUNT_UP_MIN_PULSE;
  logic       ZERO;
  logic [1:0] SEC_HOLD_STATE;
  logic [1:0] MIN_HOLD_STATE;

  modport master (
    output SEC_PUSH, MIN_PUSH, SEC_HOLD, MIN_HOLD, HALF_SEC_PULSE, TENTH_SEC_PULSE,
           UP_DOWN_TOGGLE, CLEAR,
    input  M_HI, M_LO, S_HI, S_LO, DOWN_MODE, COUNT_UP_SEC_PULSE, COUNT_UP_MIN_PULSE,
           ZERO, SEC_HOLD_STATE, MIN_HOLD_STATE
  );

  modport slave (
    input  SEC_PUSH, MIN_PUSH, SEC_HOLD, MIN_HOLD, HALF_SEC_PULSE, TENTH_SEC_PULSE,
           UP_DOWN_TOGGLE, CLEAR,
    output M_HI, M_LO, S_HI, S_LO, DOWN_MODE, COUNT_UP_SEC_PULSE, COUNT_UP_MIN_PULSE,
           ZERO, SEC_HOLD_STATE, MIN_HOLD_STATE
  );
endinterface

// File: rtl/time_preset_ctrl.sv
// BCD mm:ss preset with push/hold stepping, up/down mode, clear and zero flag.
// Inputs are level/pulse signals with no handshake; every input is sampled each CLK edge.
module time_preset_ctrl #(
  parameter int MIN_LIMIT     = 99,
  parameter int HOLD_FAST_CNT = 4,
  parameter int CARRY_EN      = 1
) (
  input  logic              CLK,
  input  logic              RES,
  time_preset_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SLOW = 2'd1;
  localparam logic [1:0] ST_FAST = 2'd2;
  localparam logic [3:0] M_MAX_HI = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] M_MAX_LO = 4'(MIN_LIMIT % 10);
  localparam logic [3:0] FAST_AT  = 4'(HOLD_FAST_CNT);

  // Index 0 is the seconds button, index 1 the minutes button.
  logic [1:0] st_q  [2];
  logic [3:0] cnt_q [2];
  logic [1:0] hold;
  logic [1:0] rep;

  logic [3:0] m_hi_q, m_lo_q, s_lo_q;
  logic [2:0] s_hi_q;
  logic [3:0] m_hi_n, m_lo_n, s_lo_n;
  logic [2:0] s_hi_n;
  logic       down_q, sec_pls_q, min_pls_q;
  logic       sec_ev, min_ev, s_wrap, m_step;

  assign hold = {bus.MIN_HOLD, bus.SEC_HOLD};

  always_comb begin
    rep = '0;
    for (int i = 0; i < 2; i++)
      rep[i] = hold[i] && ((st_q[i] == ST_SLOW && bus.HALF_SEC_PULSE) ||
                           (st_q[i] == ST_FAST && bus.TENTH_SEC_PULSE));
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (RES || bus.CLEAR || !hold[i]) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= 4'd0;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            st_q[i]  <= ST_SLOW;
            cnt_q[i] <= 4'd0;
          end
          ST_SLOW: begin
            if (bus.HALF_SEC_PULSE) begin
              cnt_q[i] <= cnt_q[i] + 4'd1;
              if (cnt_q[i] + 4'd1 == FAST_AT) st_q[i] <= ST_FAST;
            end
          end
          ST_FAST: st_q[i] <= ST_FAST;
          default: st_q[i] <= ST_IDLE;
        endcase
      end
    end
  end

  // A push and a repeat in the same cycle merge into one event.
  assign sec_ev = bus.SEC_PUSH | rep[0];
  assign min_ev = bus.MIN_PUSH | rep[1];

  always_comb begin
    s_hi_n = s_hi_q;
    s_lo_n = s_lo_q;
    m_hi_n = m_hi_q;
    m_lo_n = m_lo_q;
    s_wrap = 1'b0;
    if (!min_ev && sec_ev) begin
      if (!down_q) begin
        if (s_lo_q == 4'd9) begin
          s_lo_n = 4'd0;
          if (s_hi_q == 3'd5) begin
            s_hi_n = 3'd0;
            s_wrap = 1'b1;
          end else begin
            s_hi_n = s_hi_q + 3'd1;
          end
        end else begin
          s_lo_n = s_lo_q + 4'd1;
        end
      end else begin
        if (s_lo_q == 4'd0) begin
          s_lo_n = 4'd9;
          if (s_hi_q == 3'd0) begin
            s_hi_n = 3'd5;
            s_wrap = 1'b1;
          end else begin
            s_hi_n = s_hi_q - 3'd1;
          end
        end else begin
          s_lo_n = s_lo_q - 4'd1;
        end
      end
    end
    // A coincident minutes event wins and the seconds event is dropped.
    m_step = min_ev || (s_wrap && (CARRY_EN != 0));
    if (m_step) begin
      if (!down_q) begin
        if (m_hi_q == M_MAX_HI && m_lo_q == M_MAX_LO) begin
          m_hi_n = 4'd0;
          m_lo_n = 4'd0;
        end else if (m_lo_q == 4'd9) begin
          m_hi_n = m_hi_q + 4'd1;
          m_lo_n = 4'd0;
        end else begin
          m_lo_n = m_lo_q + 4'd1;
        end
      end else begin
        if (m_hi_q == 4'd0 && m_lo_q == 4'd0) begin
          m_hi_n = M_MAX_HI;
          m_lo_n = M_MAX_LO;
        end else if (m_lo_q == 4'd0) begin
          m_hi_n = m_hi_q - 4'd1;
          m_lo_n = 4'd9;
        end else begin
          m_lo_n = m_lo_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES || bus.CLEAR) begin
      m_hi_q    <= 4'd0;
      m_lo_q    <= 4'd0;
      s_hi_q    <= 3'd0;
      s_lo_q    <= 4'd0;
      sec_pls_q <= 1'b0;
      min_pls_q <= 1'b0;
    end else begin
      m_hi_q    <= m_hi_n;
      m_lo_q    <= m_lo_n;
      s_hi_q    <= s_hi_n;
      s_lo_q    <= s_lo_n;
      sec_pls_q <= sec_ev && !min_ev;
      min_pls_q <= min_ev;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES)                     down_q <= 1'b0;
    else if (bus.UP_DOWN_TOGGLE) down_q <= ~down_q;
  end

  assign bus.M_HI               = m_hi_q;
  assign bus.M_LO               = m_lo_q;
  assign bus.S_HI               = s_hi_q;
  assign bus.S_LO               = s_lo_q;
  assign bus.DOWN_MODE          = down_q;
  assign bus.COUNT_UP_SEC_PULSE = sec_pls_q;
  assign bus.COUNT_UP_MIN_PULSE = min_pls_q;
  assign bus.ZERO               = (m_hi_q == 4'd0) && (m_lo_q == 4'd0) &&
                                  (s_hi_q == 3'd0) && (s_lo_q == 4'd0);
  assign bus.SEC_HOLD_STATE     = st_q[0];
  assign bus.MIN_HOLD_STATE     = st_q[1];

endmodule

// File: tb/tb_time_preset_ctrl.sv
// Directed bench for time_preset_ctrl: three instances (default, CARRY_EN=0/MIN_LIMIT=59,
// MIN_LIMIT=59) share one stimulus stream; times are compared as 16-bit BCD mm:ss.
module tb_time_preset_ctrl;
  logic clk = 1'b0;
  logic res;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [5:0] P_SEC   = 6'b000001;
  localparam logic [5:0] P_MIN   = 6'b000010;
  localparam logic [5:0] P_HALF  = 6'b000100;
  localparam logic [5:0] P_TENTH = 6'b001000;
  localparam logic [5:0] P_TOG   = 6'b010000;
  localparam logic [5:0] P_CLR   = 6'b100000;

  always #5 clk = ~clk;

  time_preset_ctrl_if a_if ();
  time_preset_ctrl_if b_if ();
  time_preset_ctrl_if c_if ();

  assign b_if.SEC_PUSH        = a_if.SEC_PUSH;
  assign b_if.MIN_PUSH        = a_if.MIN_PUSH;
  assign b_if.SEC_HOLD        = a_if.SEC_HOLD;
  assign b_if.MIN_HOLD        = a_if.MIN_HOLD;
  assign b_if.HALF_SEC_PULSE  = a_if.HALF_SEC_PULSE;
  assign b_if.TENTH_SEC_PULSE = a_if.TENTH_SEC_PULSE;
  assign b_if.UP_DOWN_TOGGLE  = a_if.UP_DOWN_TOGGLE;
  assign b_if.CLEAR           = a_if.CLEAR;
  assign c_if.SEC_PUSH        = a_if.SEC_PUSH;
  assign c_if.MIN_PUSH        = a_if.MIN_PUSH;
  assign c_if.SEC_HOLD        = a_if.SEC_HOLD;
  assign c_if.MIN_HOLD        = a_if.MIN_HOLD;
  assign c_if.HALF_SEC_PULSE  = a_if.HALF_SEC_PULSE;
  assign c_if.TENTH_SEC_PULSE = a_if.TENTH_SEC_PULSE;
  assign c_if.UP_DOWN_TOGGLE  = a_if.UP_DOWN_TOGGLE;
  assign c_if.CLEAR           = a_if.CLEAR;

  time_preset_ctrl dut_a (.CLK(clk), .RES(res), .bus(a_if.slave));
  time_preset_ctrl #(.CARRY_EN(0), .MIN_LIMIT(59)) dut_b (.CLK(clk), .RES(res), .bus(b_if.slave));
  time_preset_ctrl #(.MIN_LIMIT(59)) dut_c (.CLK(clk), .RES(res), .bus(c_if.slave));

  function automatic logic [15:0] time_a();
    return {a_if.M_HI, a_if.M_LO, 1'b0, a_if.S_HI, a_if.S_LO};
  endfunction
  function automatic logic [15:0] time_b();
    return {b_if.M_HI, b_if.M_LO, 1'b0, b_if.S_HI, b_if.S_LO};
  endfunction
  function automatic logic [15:0] time_c();
    return {c_if.M_HI, c_if.M_LO, 1'b0, c_if.S_HI, c_if.S_LO};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of pulse inputs; outputs are observed #1 after the capturing edge.
  task automatic drive(input logic [5:0] v);
    a_if.SEC_PUSH        = v[0];
    a_if.MIN_PUSH        = v[1];
    a_if.HALF_SEC_PULSE  = v[2];
    a_if.TENTH_SEC_PULSE = v[3];
    a_if.UP_DOWN_TOGGLE  = v[4];
    a_if.CLEAR           = v[5];
    tick();
    a_if.SEC_PUSH        = 1'b0;
    a_if.MIN_PUSH        = 1'b0;
    a_if.HALF_SEC_PULSE  = 1'b0;
    a_if.TENTH_SEC_PULSE = 1'b0;
    a_if.UP_DOWN_TOGGLE  = 1'b0;
    a_if.CLEAR           = 1'b0;
  endtask

  task automatic repeat_drive(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  initial begin
    res = 1'b1;
    a_if.SEC_HOLD = 1'b0;
    a_if.MIN_HOLD = 1'b0;
    drive(6'b0);
    drive(6'b0);
    res = 1'b0;
    check("rst_time", time_a(), 16'h0000);
    check("rst_zero", a_if.ZERO, 1);
    check("rst_down", a_if.DOWN_MODE, 0);
    check("rst_sec_strobe", a_if.COUNT_UP_SEC_PULSE, 0);
    check("rst_min_strobe", a_if.COUNT_UP_MIN_PULSE, 0);
    check("rst_state", a_if.SEC_HOLD_STATE, 0);

    for (int i = 1; i <= 12; i++) begin
      drive(P_SEC);
      check("push_strobe", a_if.COUNT_UP_SEC_PULSE, 1);
      check("push_no_min", a_if.COUNT_UP_MIN_PULSE, 0);
      tick();
      check("push_strobe_off", a_if.COUNT_UP_SEC_PULSE, 0);
    end
    check("twelve_time", time_a(), 16'h0012);
    check("twelve_zero", a_if.ZERO, 0);

    repeat_drive(P_SEC, 47);
    check("at59_a", time_a(), 16'h0059);
    check("at59_b", time_b(), 16'h0059);
    drive(P_SEC);
    check("carry_a", time_a(), 16'h0100);
    check("nocarry_b", time_b(), 16'h0000);
    check("carry_c", time_c(), 16'h0100);
    check("carry_sec_strobe", a_if.COUNT_UP_SEC_PULSE, 1);
    check("carry_no_min_strobe", a_if.COUNT_UP_MIN_PULSE, 0);

    drive(P_CLR);
    check("clear_a", time_a(), 16'h0000);
    check("clear_c", time_c(), 16'h0000);
    check("clear_zero", a_if.ZERO, 1);
    drive(P_TOG);
    check("toggle_down", a_if.DOWN_MODE, 1);
    drive(P_SEC);
    check("borrow_a", time_a(), 16'h9959);
    check("noborrow_b", time_b(), 16'h0059);
    check("borrow_c", time_c(), 16'h5959);
    drive(P_TOG | P_SEC);
    check("tog_step_a", time_a(), 16'h9958);
    check("tog_step_b", time_b(), 16'h0058);
    check("tog_step_down", a_if.DOWN_MODE, 0);
    drive(P_SEC);
    check("up_again_a", time_a(), 16'h9959);
    drive(P_SEC);
    check("wrap_top_a", time_a(), 16'h0000);
    check("wrap_top_b", time_b(), 16'h0000);
    check("wrap_top_c", time_c(), 16'h0000);

    repeat_drive(P_MIN, 5);
    repeat_drive(P_SEC, 30);
    check("at0530", time_a(), 16'h0530);
    drive(P_SEC | P_MIN);
    check("coinc_time", time_a(), 16'h0630);
    check("coinc_min_strobe", a_if.COUNT_UP_MIN_PULSE, 1);
    check("coinc_sec_strobe", a_if.COUNT_UP_SEC_PULSE, 0);

    drive(P_CLR);
    a_if.SEC_HOLD = 1'b1;
    tick();
    check("hold_slow", a_if.SEC_HOLD_STATE, 1);
    for (int k = 1; k <= 4; k++) begin
      drive(P_TENTH);
      check("slow_ignores_tenth", time_a(), 16'(k - 1));
      drive(P_HALF);
      check("slow_step", time_a(), 16'(k));
      check("slow_strobe", a_if.COUNT_UP_SEC_PULSE, 1);
    end
    check("hold_fast", a_if.SEC_HOLD_STATE, 2);
    drive(P_HALF);
    check("fast_ignores_half", time_a(), 16'h0004);
    for (int k = 5; k <= 7; k++) begin
      drive(P_TENTH);
      check("fast_step", time_a(), 16'(k));
    end
    a_if.SEC_HOLD = 1'b0;
    tick();
    check("release_idle", a_if.SEC_HOLD_STATE, 0);
    drive(P_TENTH);
    drive(P_HALF);
    check("release_no_step", time_a(), 16'h0007);

    drive(P_CLR);
    repeat_drive(P_MIN, 12);
    repeat_drive(P_SEC, 34);
    check("at1234", time_a(), 16'h1234);
    drive(P_TOG);
    a_if.SEC_HOLD = 1'b1;
    tick();
    repeat_drive(P_HALF, 4);
    check("down_hold_time", time_a(), 16'h1230);
    check("down_hold_fast", a_if.SEC_HOLD_STATE, 2);
    drive(P_CLR | P_TENTH);
    check("clr_fast_time", time_a(), 16'h0000);
    check("clr_fast_state", a_if.SEC_HOLD_STATE, 0);
    check("clr_fast_down", a_if.DOWN_MODE, 1);
    check("clr_fast_strobe", a_if.COUNT_UP_SEC_PULSE, 0);
    tick();
    drive(P_HALF);
    check("rehold_borrow", time_a(), 16'h9959);
    res = 1'b1;
    drive(P_HALF | P_TOG | P_SEC);
    res = 1'b0;
    check("res_hold_time", time_a(), 16'h0000);
    check("res_hold_down", a_if.DOWN_MODE, 0);
    check("res_hold_strobe", a_if.COUNT_UP_SEC_PULSE, 0);
    check("res_hold_state", a_if.SEC_HOLD_STATE, 0);
    check("res_hold_zero", a_if.ZERO, 1);
    a_if.SEC_HOLD = 1'b0;

    a_if.MIN_HOLD = 1'b1;
    tick();
    check("min_hold_slow", a_if.MIN_HOLD_STATE, 1);
    drive(P_HALF);
    check("min_hold_step", time_a(), 16'h0100);
    check("min_hold_strobe", a_if.COUNT_UP_MIN_PULSE, 1);
    a_if.MIN_HOLD = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
